// File: rtl/timer_ctrl.sv
// rtl/timer_ctrl.sv - prescaled one-shot/periodic timer sequencing an external increment counter
//
// Purpose: drives a downstream DW-bit increment counter (load/enable/increment)
//          from a PW-bit prescaler, raises a sticky irq and a one-cycle expired
//          pulse each time the counter reaches period-1 on a tick.
// Ports:
//   clk, nreset         clock, asynchronous active-low reset
//   start, stop         (re)start request, abort request (start wins)
//   mode                0 one-shot, 1 periodic (sampled on accepted start)
//   period, prescale    ticks per expiry, clocks per tick minus 1 (sampled on start)
//   irq_clear           clears the sticky irq
//   cnt_count, cnt_carry  current value and carry-out of the downstream counter
//   cnt_load, cnt_load_data, cnt_en, cnt_in  downstream counter controls
//   busy, irq, expired, err  status outputs
module timer_ctrl #(
  parameter int DW = 32,
  parameter int PW = 8
) (
  input  logic          clk,
  input  logic          nreset,
  input  logic          start,
  input  logic          stop,
  input  logic          mode,
  input  logic [DW-1:0] period,
  input  logic [PW-1:0] prescale,
  input  logic          irq_clear,
  input  logic [DW-1:0] cnt_count,
  input  logic          cnt_carry,
  output logic          cnt_load,
  output logic [DW-1:0] cnt_load_data,
  output logic          cnt_en,
  output logic          cnt_in,
  output logic          busy,
  output logic          irq,
  output logic          expired,
  output logic          err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state;
  logic [PW-1:0] pre_cnt;
  logic [DW-1:0] period_q;
  logic [PW-1:0] prescale_q;
  logic          mode_q;

  logic accept;
  logic reject;
  logic running;
  logic tick;
  logic match;

  assign accept  = start && (period != '0);
  assign reject  = start && (period == '0);
  assign running = (state == RUN);

  // No tick in the start cycle: the counter is being loaded then, and the
  // prescaler restarts from 0 on the next edge.
  assign tick  = running && !accept && (pre_cnt == prescale_q);
  assign match = tick && (cnt_count == (period_q - DW'(1)));

  // A periodic match reloads 0 instead of incrementing, so each period is
  // exactly period_q ticks long with no drift. The load strobe is
  // combinational from start, so it is masked while reset is held.
  assign cnt_load      = nreset && (accept || (match && mode_q));
  assign cnt_load_data = '0;
  assign cnt_en        = running;
  assign cnt_in        = tick;
  assign busy          = running;

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state      <= IDLE;
      pre_cnt    <= '0;
      irq        <= 1'b0;
      expired    <= 1'b0;
      err        <= 1'b0;
      period_q   <= '0;
      prescale_q <= '0;
      mode_q     <= 1'b0;
    end else begin
      expired <= match;

      // Setting wins over clearing in the same cycle.
      if (match) begin
        irq <= 1'b1;
      end else if (irq_clear) begin
        irq <= 1'b0;
      end

      if (reject || (cnt_carry && running)) begin
        err <= 1'b1;
      end

      if (accept) begin
        period_q   <= period;
        prescale_q <= prescale;
        mode_q     <= mode;
        pre_cnt    <= '0;
        state      <= RUN;
      end else if (reject) begin
        state <= state;
      end else if (stop && (state != IDLE)) begin
        pre_cnt <= '0;
        state   <= IDLE;
      end else if (running) begin
        pre_cnt <= tick ? '0 : pre_cnt + PW'(1);
        if (match && !mode_q) begin
          state <= DONE;
        end
      end
    end
  end

endmodule

// File: doc/timer_ctrl.md
TIMER_CTRL -- requirements
Module: timer_ctrl

Interface
REQ-001 Parameter DW, default 32, SHALL set the width of period, count and load data.
REQ-002 Parameter PW, default 8, SHALL set the width of the prescale value.
REQ-003 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 nreset  input  1  SHALL be the reset: asynchronous, active-low.
REQ-005 start  input  1  SHALL request a (re)start of the timer.
REQ-006 stop  input  1  SHALL request an abort to IDLE.
REQ-007 mode  input  1  SHALL select the mode: 0 one-shot, 1 periodic; sampled on accepted start.
REQ-008 period  input  DW  SHALL give the ticks per expiry; sampled on accepted start.
REQ-009 prescale  input  PW  SHALL give the clocks per tick minus 1; sampled on accepted start.
REQ-010 irq_clear  input  1  SHALL clear the sticky irq.
REQ-011 cnt_count  input  DW  SHALL carry the current value from the downstream increment counter.
REQ-012 cnt_carry  input  1  SHALL carry the carry-out from the downstream counter.
REQ-013 cnt_load  output  1  SHALL be the counter load strobe (combinational).
REQ-014 cnt_load_data  output  DW  SHALL be the counter load value, constant 0.
REQ-015 cnt_en  output  1  SHALL be the counter enable; high iff state==RUN.
REQ-016 cnt_in  output  1  SHALL be the counter increment input; equal to tick.
REQ-017 busy  output  1  SHALL be high iff state==RUN.
REQ-018 irq  output  1  SHALL be the sticky expiry flag.
REQ-019 expired  output  1  SHALL be a one-cycle registered pulse per expiry.
REQ-020 err  output  1  SHALL be a sticky flag for a rejected start or a counter overflow.

Function
REQ-021 States SHALL be IDLE, RUN and DONE.
REQ-022 A start SHALL be accepted when start=1 and period!=0, in any state.
- Accepted start: period_q, prescale_q and mode_q captured; pre_cnt=0; state->RUN; cnt_load=1 in the same cycle.
REQ-023 A start with period==0 SHALL be rejected: err set, state unchanged.
REQ-024 In RUN, pre_cnt SHALL increment each clock, and tick=1 when pre_cnt==prescale_q, with pre_cnt wrapping to 0 on a tick.
REQ-025 tick SHALL be 0 outside RUN and in the cycle of an accepted start.
REQ-026 match SHALL equal tick & (cnt_count==period_q-1) in DW-bit arithmetic.
REQ-027 On match, the next edge SHALL set irq and pulse expired.
- mode_q=1: cnt_load=1 in the match cycle (counter reloads 0 instead of incrementing); state stays RUN.
- mode_q=0: state->DONE; cnt_en low from the next cycle.
REQ-028 The expiry interval SHALL be exactly (prescale_q+1)*period_q clocks with no drift across periods.
REQ-029 stop in RUN or DONE SHALL move the state to IDLE at the next edge and clear pre_cnt.
REQ-030 A simultaneous stop and match SHALL still set irq and pulse expired, then the state SHALL go to IDLE.
REQ-031 start SHALL have priority over stop in the same cycle.
REQ-032 irq set and irq_clear in the same cycle SHALL leave irq=1.
REQ-033 cnt_carry=1 while in RUN SHALL set err.
REQ-034 err SHALL clear only on reset.
REQ-035 The block SHALL tolerate prescale_q=0, giving one tick per clock.
REQ-036 The block SHALL tolerate period_q=1, giving expiry on every tick.

Reset
REQ-037 nreset low SHALL immediately force state=IDLE, pre_cnt=0, irq=0, expired=0, err=0, period_q=0, prescale_q=0 and mode_q=0.
REQ-038 While nreset is low, all outputs SHALL be 0.
REQ-039 Reset asserted mid-RUN SHALL abort without an irq.
REQ-040 After release, the block SHALL be idle until the next accepted start.

Verification
REQ-041 The bench SHALL connect a DW-bit increment counter model to the cnt_* ports.
REQ-042 One-shot: start at cycle 0, prescale=2, period=4, mode=0 -> expired pulse at cycle 13, irq=1 from cycle 13, busy=0 from 13.
REQ-043 Periodic: prescale=0, period=3, mode=1 -> expired at cycles 4, 7 and 10, with cnt_load high at cycles 0, 3, 6 and 9.
REQ-044 Zero period: start with period=0 -> err=1 next cycle, busy stays 0, cnt_load stays 0.
REQ-045 Simultaneous events: irq_clear in the same cycle as a match keeps irq=1; stop in the match cycle gives irq=1 and IDLE.
REQ-046 Restart and reset: start mid-RUN restarts from count 0 with a full interval; nreset low mid-RUN clears all outputs immediately.
